// File: rtl/instruction_fetch_controller.sv
// Dual-word fetch sequencer: drives the fetch PC, queues PC/PC+4 pairs and
// presents the two oldest entries to dual decode, with full flush on redirect.
module instruction_fetch_controller #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned FQ_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       fetch_en,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  output logic [31:0]                Program_counter_IM,
  input  logic [1:0][31:0]           Instruction_IM,
  input  logic [1:0]                 deq_count,
  output logic [1:0]                 dec_valid,
  output logic [31:0]                dec_instr0,
  output logic [31:0]                dec_instr1,
  output logic [31:0]                dec_pc0,
  output logic [31:0]                dec_pc1,
  output logic [$clog2(FQ_DEPTH):0]  fq_count
);

  localparam int unsigned PtrW = $clog2(FQ_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StBoot, StRun, StHold} state_e;

  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [CntW-1:0]   fq_count_q, fq_count_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [31:0]       q_pc    [FQ_DEPTH];
  logic [31:0]       q_instr [FQ_DEPTH];

  logic [1:0]        deq_eff, deq_acc;
  logic [CntW-1:0]   remain;
  logic              space, can_fetch, enq;
  logic [PtrW-1:0]   rd_idx1, wr_idx1;
  logic              unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Pointer advance modulo FQ_DEPTH; depth need not be a power of two.
  function automatic logic [PtrW-1:0] wrap_add(input logic [PtrW-1:0] ptr,
                                               input logic [1:0] inc);
    logic [CntW-1:0] sum;
    sum = CntW'(ptr) + CntW'(inc);
    if (sum >= CntW'(FQ_DEPTH)) sum = sum - CntW'(FQ_DEPTH);
    return sum[PtrW-1:0];
  endfunction

  always_comb begin
    deq_eff   = (deq_count == 2'd3) ? 2'd2 : deq_count;
    deq_acc   = (CntW'(deq_eff) > fq_count_q) ? fq_count_q[1:0] : deq_eff;
    remain    = fq_count_q - CntW'(deq_acc);
    // Same-cycle dequeue counts toward space, so decode can keep fetch streaming.
    space     = (remain <= CntW'(FQ_DEPTH - 2));
    can_fetch = fetch_en && space;
    enq       = (state_q != StBoot) && can_fetch && !redirect_valid;
    rd_idx1   = wrap_add(rd_ptr_q, 2'd1);
    wr_idx1   = wrap_add(wr_ptr_q, 2'd1);
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fq_count_d = remain + (enq ? CntW'(2) : CntW'(0));
    rd_ptr_d   = wrap_add(rd_ptr_q, deq_acc);
    wr_ptr_d   = enq ? wrap_add(wr_ptr_q, 2'd2) : wr_ptr_q;
    if (enq) pc_d = pc_q + 32'd8;

    unique case (state_q)
      StBoot:  state_d = StRun;
      StRun:   if (!can_fetch) state_d = StHold;
      StHold:  if (can_fetch) state_d = StRun;
      default: state_d = StBoot;
    endcase

    if (redirect_valid) begin
      state_d    = StRun;
      pc_d       = {redirect_pc[31:2], 2'b00};
      fq_count_d = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StBoot;
      pc_q       <= RESET_PC;
      fq_count_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fq_count_q <= fq_count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Payload storage needs no reset; validity comes from fq_count alone.
  always_ff @(posedge clk) begin
    if (rst_n && enq) begin
      q_pc[wr_ptr_q]    <= pc_q;
      q_instr[wr_ptr_q] <= Instruction_IM[0];
      q_pc[wr_idx1]     <= pc_q + 32'd4;
      q_instr[wr_idx1]  <= Instruction_IM[1];
    end
  end

  always_comb begin
    dec_valid[0] = (fq_count_q >= CntW'(1));
    dec_valid[1] = (fq_count_q >= CntW'(2));
    dec_pc0      = dec_valid[0] ? q_pc[rd_ptr_q]    : 32'd0;
    dec_instr0   = dec_valid[0] ? q_instr[rd_ptr_q] : 32'd0;
    dec_pc1      = dec_valid[1] ? q_pc[rd_idx1]     : 32'd0;
    dec_instr1   = dec_valid[1] ? q_instr[rd_idx1]  : 32'd0;
  end

  assign Program_counter_IM = pc_q;
  assign fq_count           = fq_count_q;

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Directed bench for instruction_fetch_controller; memory word at byte
// address A holds A>>2, so every instruction value is predictable.
module tb_instruction_fetch_controller;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            fetch_en;
  logic            redirect_valid;
  logic [31:0]     redirect_pc;
  logic [31:0]     Program_counter_IM;
  logic [1:0][31:0] Instruction_IM;
  logic [1:0]      deq_count;
  logic [1:0]      dec_valid;
  logic [31:0]     dec_instr0, dec_instr1, dec_pc0, dec_pc1;
  logic [2:0]      fq_count;

  int errors = 0;
  int checks = 0;

  instruction_fetch_controller #(
    .RESET_PC (32'h0000_0100),
    .FQ_DEPTH (4)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .fetch_en           (fetch_en),
    .redirect_valid     (redirect_valid),
    .redirect_pc        (redirect_pc),
    .Program_counter_IM (Program_counter_IM),
    .Instruction_IM     (Instruction_IM),
    .deq_count          (deq_count),
    .dec_valid          (dec_valid),
    .dec_instr0         (dec_instr0),
    .dec_instr1         (dec_instr1),
    .dec_pc0            (dec_pc0),
    .dec_pc1            (dec_pc1),
    .fq_count           (fq_count)
  );

  always #5 clk = ~clk;

  assign Instruction_IM[0] = Program_counter_IM >> 2;
  assign Instruction_IM[1] = (Program_counter_IM + 32'd4) >> 2;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; deq_count = 2'd0;
    // T1 reset
    tick(); tick();
    check("rst_pc", Program_counter_IM, 32'h100);
    check("rst_cnt", 32'(fq_count), 32'd0);
    check("rst_valid", 32'(dec_valid), 32'd0);
    check("rst_pc0", dec_pc0, 32'd0);

    // T2 streaming with deq_count=2
    rst_n = 1'b1; fetch_en = 1'b1; deq_count = 2'd2;
    tick();  // BOOT cycle: no enqueue
    check("boot_cnt", 32'(fq_count), 32'd0);
    check("boot_pc", Program_counter_IM, 32'h100);
    tick();
    check("s1_cnt", 32'(fq_count), 32'd2);
    check("s1_pc", Program_counter_IM, 32'h108);
    check("s1_valid", 32'(dec_valid), 32'd3);
    check("s1_pc0", dec_pc0, 32'h100);
    check("s1_pc1", dec_pc1, 32'h104);
    check("s1_i0", dec_instr0, 32'h40);
    check("s1_i1", dec_instr1, 32'h41);
    tick();
    check("s2_pc", Program_counter_IM, 32'h110);
    check("s2_pc0", dec_pc0, 32'h108);
    check("s2_pc1", dec_pc1, 32'h10C);
    check("s2_i0", dec_instr0, 32'h42);

    // T3 back-pressure
    deq_count = 2'd0;
    tick();
    check("bp1_cnt", 32'(fq_count), 32'd4);
    check("bp1_pc", Program_counter_IM, 32'h118);
    tick();
    check("bp2_cnt", 32'(fq_count), 32'd4);
    check("bp2_pc", Program_counter_IM, 32'h118);
    check("bp2_pc0", dec_pc0, 32'h108);
    deq_count = 2'd1;
    tick();
    check("bp3_cnt", 32'(fq_count), 32'd3);
    check("bp3_pc", Program_counter_IM, 32'h118);
    check("bp3_pc0", dec_pc0, 32'h10C);
    deq_count = 2'd2;
    tick();
    check("bp4_cnt", 32'(fq_count), 32'd3);
    check("bp4_pc", Program_counter_IM, 32'h120);
    check("bp4_pc0", dec_pc0, 32'h114);
    check("bp4_pc1", dec_pc1, 32'h118);
    deq_count = 2'd1;
    tick();
    check("bp5_cnt", 32'(fq_count), 32'd4);
    check("bp5_pc0", dec_pc0, 32'h118);

    // T4 redirect while full with deq_count=2
    redirect_valid = 1'b1; redirect_pc = 32'h203; deq_count = 2'd2;
    tick();
    check("rd_cnt", 32'(fq_count), 32'd0);
    check("rd_valid", 32'(dec_valid), 32'd0);
    check("rd_pc", Program_counter_IM, 32'h200);
    check("rd_pc0", dec_pc0, 32'd0);
    redirect_valid = 1'b0;
    tick();
    check("rd2_cnt", 32'(fq_count), 32'd2);
    check("rd2_pc0", dec_pc0, 32'h200);
    check("rd2_i0", dec_instr0, 32'h80);
    check("rd2_pc", Program_counter_IM, 32'h208);

    // Back-to-back redirects: last wins
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    tick();
    redirect_pc = 32'h404;
    tick();
    check("bb_pc", Program_counter_IM, 32'h404);
    check("bb_cnt", 32'(fq_count), 32'd0);
    redirect_valid = 1'b0;
    tick();
    check("bb2_pc0", dec_pc0, 32'h404);

    // T5 32-bit PC wrap
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    tick();
    check("wr_pc", Program_counter_IM, 32'hFFFF_FFF8);
    redirect_valid = 1'b0;
    tick();
    check("wr_pc0", dec_pc0, 32'hFFFF_FFF8);
    check("wr_pc1", dec_pc1, 32'hFFFF_FFFC);
    check("wr_i1", dec_instr1, 32'h3FFF_FFFF);
    check("wr_nextpc", Program_counter_IM, 32'd0);
    tick();
    check("wr2_pc0", dec_pc0, 32'd0);
    check("wr2_pc1", dec_pc1, 32'd4);
    check("wr2_pc", Program_counter_IM, 32'd8);

    // T6 fetch_en=0 drains queue; deq_count beyond occupancy is clamped
    fetch_en = 1'b0; deq_count = 2'd1;
    tick();
    check("fz_cnt", 32'(fq_count), 32'd1);
    check("fz_pc", Program_counter_IM, 32'd8);
    check("fz_pc0", dec_pc0, 32'd4);
    check("fz_valid", 32'(dec_valid), 32'd1);
    check("fz_pc1", dec_pc1, 32'd0);
    deq_count = 2'd2;
    tick();
    check("cl_cnt", 32'(fq_count), 32'd0);
    check("cl_valid", 32'(dec_valid), 32'd0);
    check("cl_pc", Program_counter_IM, 32'd8);
    fetch_en = 1'b1; deq_count = 2'd0;
    tick();
    check("rs_cnt", 32'(fq_count), 32'd2);
    check("rs_pc0", dec_pc0, 32'd8);
    check("rs_pc", Program_counter_IM, 32'h10);
    deq_count = 2'd3;
    tick();
    check("d3_cnt", 32'(fq_count), 32'd2);
    check("d3_pc0", dec_pc0, 32'h10);
    check("d3_pc", Program_counter_IM, 32'h18);

    // Mid-stream reset
    rst_n = 1'b0;
    tick();
    check("mr_pc", Program_counter_IM, 32'h100);
    check("mr_cnt", 32'(fq_count), 32'd0);
    check("mr_valid", 32'(dec_valid), 32'd0);
    rst_n = 1'b1; deq_count = 2'd2;
    tick();
    check("mr_boot_cnt", 32'(fq_count), 32'd0);
    tick();
    check("mr2_cnt", 32'(fq_count), 32'd2);
    check("mr2_pc0", dec_pc0, 32'h100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
